// File: rtl/gpcore_mem_pkg.sv
// Shared load/store definitions for the GPCore memory path: funct3 sizes,
// the response record, and the load extraction/extension helper.
package gpcore_mem_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mem_resp_t;

  // Pick the addressed byte/half out of an aligned word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [2:0]  funct3,
                                               input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(word >> {off, 3'b000});
    h = off[1] ? word[31:16] : word[15:0];
    case (funct3)
      MEM_B:   r = {{24{b[7]}}, b};
      MEM_BU:  r = {24'h0, b};
      MEM_H:   r = {{16{h[15]}}, h};
      MEM_HU:  r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic funct3_illegal(input logic we, input logic [2:0] funct3);
    logic legal;
    legal = (funct3 == MEM_B) || (funct3 == MEM_H) || (funct3 == MEM_W) ||
            (!we && ((funct3 == MEM_BU) || (funct3 == MEM_HU)));
    return !legal;
  endfunction

endpackage

// File: rtl/dmem_responder_resp_fifo.sv
// Response FIFO for the data-memory responder; holds mem_resp_t records and
// accepts a push into a full FIFO when the head pops on the same edge.
module resp_fifo
  import gpcore_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  mem_resp_t     push_data,
  input  logic          pop,
  output mem_resp_t     head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  mem_resp_t     store [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_incr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = count_reg;
  assign head    = store[rd_ptr_reg];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_incr(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_incr(rd_ptr_reg);
      count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word array with byte-lane stores, fixed-latency load
// pipe, credit-counted request acceptance and an in-order response FIFO.
module dmem_responder
  import gpcore_mem_pkg::*;
#(
  parameter int          MEM_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          LATENCY    = 2,
  parameter int          RESP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IW = $clog2(MEM_WORDS);
  localparam int OW = $clog2(RESP_DEPTH + 1);

  typedef struct packed {
    logic       valid;
    logic       we;
    logic       err;
    logic [2:0] funct3;
    logic [1:0] off;
  } pipe_meta_t;

  logic [31:0]   mem [MEM_WORDS];
  logic [31:0]   word_reg [LATENCY];
  pipe_meta_t    meta_reg [LATENCY];
  logic [OW-1:0] outstanding_reg;
  logic [OW-1:0] outstanding_next;

  logic          accept;
  logic          pop;
  logic          req_err;
  logic          wr_en;
  logic [31:0]   offset;
  logic [31:0]   word_off;
  logic [IW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wlane;
  pipe_meta_t    tail;
  mem_resp_t     push_data;
  mem_resp_t     head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [OW-1:0] fifo_count;

  // Credits cover pipe + FIFO, so the ready path never sees resp_ready.
  assign req_ready = !rst && (outstanding_reg < OW'(RESP_DEPTH));
  assign accept    = req_valid && req_ready;
  assign pop       = !fifo_empty && resp_ready;
  assign wr_en     = accept && req_we && !req_err;

  always_comb begin
    offset   = req_addr - BASE_ADDR;
    word_off = offset >> 2;
    idx      = word_off[IW-1:0];
    req_err  = funct3_illegal(req_we, req_funct3) ||
               (((req_funct3 == MEM_H) || (req_funct3 == MEM_HU)) && req_addr[0]) ||
               ((req_funct3 == MEM_W) && (req_addr[1:0] != 2'b00)) ||
               (word_off >= 32'(MEM_WORDS));
    be    = 4'b1111;
    wlane = req_wdata;
    case (req_funct3)
      MEM_B: begin
        be    = 4'b0001 << req_addr[1:0];
        wlane = {4{req_wdata[7:0]}};
      end
      MEM_H: begin
        be    = 4'b0011 << req_addr[1:0];
        wlane = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Array and word pipe carry no reset: contents survive rst by design.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
    word_reg[0] <= mem[idx];
    for (int i = 1; i < LATENCY; i++) word_reg[i] <= word_reg[i-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) meta_reg[i] <= '0;
      outstanding_reg <= '0;
    end else begin
      meta_reg[0]     <= '{valid: accept, we: req_we, err: req_err,
                           funct3: req_funct3, off: req_addr[1:0]};
      for (int i = 1; i < LATENCY; i++) meta_reg[i] <= meta_reg[i-1];
      outstanding_reg <= outstanding_next;
    end
  end

  assign outstanding_next = outstanding_reg + OW'(accept) - OW'(pop);

  always_comb begin
    tail            = meta_reg[LATENCY-1];
    push_data.err   = tail.err;
    push_data.rdata = (tail.err || tail.we) ? 32'h0
                    : load_extend(word_reg[LATENCY-1], tail.funct3, tail.off);
  end

  resp_fifo #(.DEPTH(RESP_DEPTH)) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tail.valid),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign resp_valid = !fifo_empty;
  assign resp_rdata = fifo_empty ? 32'h0 : head.rdata;
  assign resp_err   = !fifo_empty && head.err;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(fifo_full && tail.valid && !pop));
  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    fifo_count <= outstanding_reg);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table run at full throughput,
// then backpressure and reset-in-flight sequences.
module tb_dmem_responder;
  import gpcore_mem_pkg::*;

  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int WORDS = 1024;
  localparam int NV    = 26;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b010;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;

  dmem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(32'h0), .LATENCY(LAT), .RESP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t        vecs [NV];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          acc_q [$];
  int          rc_q [$];
  logic [31:0] rd_q [$];
  logic        er_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Sample just before the next rising edge; record accepts and pops it will perform.
  always @(negedge clk) begin
    #4;
    if (req_valid && req_ready) acc_q.push_back(cyc + 1);
    if (resp_valid && resp_ready) begin
      rd_q.push_back(resp_rdata);
      er_q.push_back(resp_err);
      rc_q.push_back(cyc);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clear_q();
    acc_q.delete(); rc_q.delete(); rd_q.delete(); er_q.delete();
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int t = 0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    #1;
    while (!req_ready && t < 50) begin
      @(negedge clk); #1; t++;
    end
    if (!req_ready) begin
      n_vec++; n_bad++;
      $display("FAIL accept_timeout: addr %h never accepted", a);
    end
    @(negedge clk);
  endtask

  task automatic wait_resps(input int n);
    int t = 0;
    while (rd_q.size() < n && t < 200) begin
      @(negedge clk); t++;
    end
    if (rd_q.size() < n) begin
      n_vec++; n_bad++;
      $display("FAIL resp_timeout: got %0d responses, expected %0d", rd_q.size(), n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, MEM_W,  32'h10,       32'hDEADBEEF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, MEM_W,  32'h10,       32'h0,        32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, MEM_W,  32'h20,       32'h80817F80, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, MEM_B,  32'h20,       32'h0,        32'hFFFFFF80, 1'b0};
    vecs[4]  = '{1'b0, MEM_BU, 32'h21,       32'h0,        32'h0000007F, 1'b0};
    vecs[5]  = '{1'b0, MEM_H,  32'h22,       32'h0,        32'hFFFF8081, 1'b0};
    vecs[6]  = '{1'b0, MEM_HU, 32'h22,       32'h0,        32'h00008081, 1'b0};
    vecs[7]  = '{1'b1, MEM_B,  32'h23,       32'h123456AA, 32'h0,        1'b0};
    vecs[8]  = '{1'b0, MEM_W,  32'h20,       32'h0,        32'hAA817F80, 1'b0};
    vecs[9]  = '{1'b0, MEM_W,  32'h22,       32'h0,        32'h0,        1'b1};
    vecs[10] = '{1'b1, MEM_H,  32'h21,       32'h00001234, 32'h0,        1'b1};
    vecs[11] = '{1'b0, MEM_W,  32'h20,       32'h0,        32'hAA817F80, 1'b0};
    vecs[12] = '{1'b0, MEM_W,  32'h1000,     32'h0,        32'h0,        1'b1};
    vecs[13] = '{1'b0, 3'b011, 32'h20,       32'h0,        32'h0,        1'b1};
    vecs[14] = '{1'b1, MEM_BU, 32'h20,       32'h000000FF, 32'h0,        1'b1};
    vecs[15] = '{1'b1, 3'b111, 32'h20,       32'hFFFFFFFF, 32'h0,        1'b1};
    vecs[16] = '{1'b1, MEM_H,  32'h22,       32'hFFFFBEEF, 32'h0,        1'b0};
    vecs[17] = '{1'b0, MEM_W,  32'h20,       32'h0,        32'hBEEF7F80, 1'b0};
    vecs[18] = '{1'b0, MEM_H,  32'h20,       32'h0,        32'h00007F80, 1'b0};
    vecs[19] = '{1'b0, MEM_B,  32'h23,       32'h0,        32'hFFFFFFBE, 1'b0};
    vecs[20] = '{1'b0, MEM_BU, 32'h23,       32'h0,        32'h000000BE, 1'b0};
    vecs[21] = '{1'b1, MEM_W,  32'hFFC,      32'h12345678, 32'h0,        1'b0};
    vecs[22] = '{1'b0, MEM_HU, 32'hFFE,      32'h0,        32'h00001234, 1'b0};
    vecs[23] = '{1'b0, MEM_W,  32'hFFFFFFF0, 32'h0,        32'h0,        1'b1};
    vecs[24] = '{1'b0, MEM_H,  32'h23,       32'h0,        32'h0,        1'b1};
    vecs[25] = '{1'b0, MEM_W,  32'h10,       32'h0,        32'hDEADBEEF, 1'b0};

    // Reset values, asserted asynchronously between clock edges.
    #1 rst = 1'b1;
    #1;
    chk("reset_req_ready",  32'(req_ready),  32'h0);
    chk("reset_resp_valid", 32'(resp_valid), 32'h0);
    chk("reset_resp_rdata", resp_rdata,      32'h0);
    chk("reset_resp_err",   32'(resp_err),   32'h0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 chk("ready_after_reset", 32'(req_ready), 32'h1);

    // Vector table, issued back to back with resp_ready held high.
    clear_q();
    for (int i = 0; i < NV; i++) drive(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata);
    req_valid = 1'b0;
    wait_resps(NV);
    chk("vec_accept_count", 32'(acc_q.size()), 32'(NV));
    if (acc_q.size() == NV) chk("vec_throughput", 32'(acc_q[NV-1] - acc_q[0]), 32'(NV - 1));
    for (int i = 0; i < NV && i < rd_q.size() && i < acc_q.size(); i++) begin
      $display("vec %0d: we=%0b f3=%b addr=%h -> rdata=%h err=%0b lat=%0d",
               i, vecs[i].we, vecs[i].f3, vecs[i].addr, rd_q[i], er_q[i], rc_q[i] - acc_q[i]);
      chk($sformatf("vec%0d_rdata", i), rd_q[i], vecs[i].exp_rdata);
      chk($sformatf("vec%0d_err", i), 32'(er_q[i]), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 32'(rc_q[i] - acc_q[i]), 32'(LAT));
    end

    // Backpressure: fill the credits, then release and drain in order.
    clear_q();
    for (int k = 0; k < 6; k++) drive(1'b1, MEM_W, 32'h100 + 32'(4 * k), 32'hB000_0000 + 32'(k));
    req_valid = 1'b0;
    wait_resps(6);
    clear_q();
    resp_ready = 1'b0;
    for (int k = 0; k < 4; k++) drive(1'b0, MEM_W, 32'h100 + 32'(4 * k), 32'h0);
    #1 chk("bp_ready_low_after_4", 32'(req_ready), 32'h0);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = MEM_W; req_addr = 32'h110;
    repeat (3) @(negedge clk);
    #1;
    chk("bp_accepts_held", 32'(acc_q.size()), 32'h4);
    chk("bp_resp_valid", 32'(resp_valid), 32'h1);
    resp_ready = 1'b1;
    #1 chk("bp_ready_no_comb_path", 32'(req_ready), 32'h0);
    @(negedge clk);
    #1 chk("bp_ready_after_pop", 32'(req_ready), 32'h1);
    drive(1'b0, MEM_W, 32'h110, 32'h0);
    drive(1'b0, MEM_W, 32'h114, 32'h0);
    req_valid = 1'b0;
    wait_resps(6);
    repeat (10) @(negedge clk);
    chk("bp_resp_count", 32'(rd_q.size()), 32'h6);
    chk("bp_accept_count", 32'(acc_q.size()), 32'h6);
    for (int k = 0; k < 6 && k < rd_q.size(); k++) begin
      $display("bp %0d: rdata=%h err=%0b", k, rd_q[k], er_q[k]);
      chk($sformatf("bp%0d_rdata", k), rd_q[k], 32'hB000_0000 + 32'(k));
    end

    // Reset with three responses in flight; the store must survive.
    clear_q();
    resp_ready = 1'b0;
    drive(1'b1, MEM_W, 32'h200, 32'h5A5A1234);
    drive(1'b0, MEM_W, 32'h100, 32'h0);
    drive(1'b0, MEM_W, 32'h104, 32'h0);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("rf_resp_valid_before", 32'(resp_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("rf_resp_valid_in_reset", 32'(resp_valid), 32'h0);
    chk("rf_req_ready_in_reset",  32'(req_ready),  32'h0);
    chk("rf_rdata_in_reset",      resp_rdata,      32'h0);
    chk("rf_err_in_reset",        32'(resp_err),   32'h0);
    @(negedge clk);
    rst = 1'b0;
    resp_ready = 1'b1;
    clear_q();
    #1 chk("rf_ready_after_release", 32'(req_ready), 32'h1);
    drive(1'b0, MEM_W, 32'h200, 32'h0);
    req_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("rf_resp_count", 32'(rd_q.size()), 32'h1);
    if (rd_q.size() > 0 && acc_q.size() > 0) begin
      $display("rf: rdata=%h err=%0b lat=%0d", rd_q[0], er_q[0], rc_q[0] - acc_q[0]);
      chk("rf_store_kept", rd_q[0], 32'h5A5A1234);
      chk("rf_err", 32'(er_q[0]), 32'h0);
      chk("rf_latency", 32'(rc_q[0] - acc_q[0]), 32'(LAT));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
